// File: rtl/ramb4_s4_port_arbiter.sv
// ramb4_s4_port_arbiter
// ---------------------------------------------------------------------------
// Shares the single 1024 x 4 port of a RAMB4 block RAM between two client
// engines with round-robin priority. Read data is routed back to whichever
// requester issued the read. After reset (optionally) or on clr_start, a
// clear sweep writes CLEAR_VAL to every word before traffic is admitted.
//
// Ports
//   CLKA              clock (RAM port-B clock is tied to the same net)
//   RSTB              synchronous active-high reset
//   reqN/weN/addrN/wdataN   request from client N, held until ackN
//   ackN              combinational accept pulse
//   rvalidN/rdataN    read return, two cycles after the read ack
//   clr_start         request a clear sweep (ignored while one is running)
//   clr_busy          clear sweep in progress
//   ram_en/ram_we/ram_rst/ram_addr/ram_din/ram_dout   RAM port-B pins
//
// Every ram_* output is a flop, so a command decided in cycle k is on the
// RAM pins in cycle k+1 and the RAM output register holds the read data in
// cycle k+2, which is when rvalidN is raised.
// ---------------------------------------------------------------------------
module ramb4_s4_port_arbiter #(
    parameter int                 ADDR_W         = 10,
    parameter int                 DATA_W         = 4,
    parameter logic [DATA_W-1:0]  CLEAR_VAL      = {DATA_W{1'b0}},
    parameter bit                 CLEAR_ON_RESET = 1'b1
) (
    input  logic              CLKA,
    input  logic              RSTB,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_rst,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_q, last_d;       // id of the last granted requester
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              tag_rd_q, tag_rd_d;   // command on the pins is a read
    logic              tag_id_q, tag_id_d;   // ... issued by this requester
    logic [1:0]        rvalid_q, rvalid_d;

    logic [1:0] req_v;
    logic [1:0] grant;
    logic       arb_open;

    assign req_v    = {req1, req0};
    // clr_start wins over any request in the cycle it is sampled.
    assign arb_open = (state_q == ST_ARB) && !clr_start;

    // On a tie the requester that was not granted last wins.
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        assign grant[gi] = arb_open && req_v[gi] &&
                           (!req_v[1-gi] || (last_q != 1'(gi)));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        ram_en_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        tag_rd_d   = 1'b0;
        tag_id_d   = tag_id_q;
        // The read on the pins this cycle returns data next cycle.
        rvalid_d   = {tag_rd_q && tag_id_q, tag_rd_q && !tag_id_q};

        if (state_q == ST_CLEAR) begin
            ram_en_d   = 1'b1;
            ram_we_d   = 1'b1;
            ram_addr_d = cnt_q;
            ram_din_d  = CLEAR_VAL;
            cnt_d      = cnt_q + ADDR_W'(1);
            // Leave as the last write is issued so arbitration resumes in
            // the cycle that write is on the pins.
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_ARB;
                cnt_d   = '0;
            end
        end else if (clr_start) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end else if (grant[0]) begin
            ram_en_d   = 1'b1;
            ram_we_d   = we0;
            ram_addr_d = addr0;
            ram_din_d  = wdata0;
            tag_rd_d   = !we0;
            tag_id_d   = 1'b0;
            last_d     = 1'b0;
        end else if (grant[1]) begin
            ram_en_d   = 1'b1;
            ram_we_d   = we1;
            ram_addr_d = addr1;
            ram_din_d  = wdata1;
            tag_rd_d   = !we1;
            tag_id_d   = 1'b1;
            last_d     = 1'b1;
        end
    end

    always_ff @(posedge CLKA) begin
        if (RSTB) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            tag_rd_q   <= 1'b0;
            tag_id_q   <= 1'b0;
            rvalid_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            tag_rd_q   <= tag_rd_d;
            tag_id_q   <= tag_id_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign ack0     = grant[0];
    assign ack1     = grant[1];
    assign rvalid0  = rvalid_q[0];
    assign rvalid1  = rvalid_q[1];
    assign rdata0   = ram_dout;
    assign rdata1   = ram_dout;
    assign clr_busy = (state_q == ST_CLEAR);
    assign ram_en   = ram_en_q;
    assign ram_we   = ram_we_q;
    assign ram_rst  = 1'b0;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ramb4_s4_port_arbiter.sv
// Testbench for ramb4_s4_port_arbiter: a behavioural RAMB4 port (write-first,
// registered output) is attached to the RAM pins; two queue-driven requesters
// issue traffic, and a cycle-level reference model (per-word memory array,
// round-robin rule, read-return scoreboard) predicts every output.
module tb_ramb4_s4_port_arbiter;

    localparam int          NW    = 1024;
    localparam logic [3:0]  CLR_V = 4'h0;

    typedef struct {
        logic       we;
        logic [9:0] addr;
        logic [3:0] data;
    } op_t;

    typedef struct {
        int         due;
        int         id;
        logic [3:0] data;
    } rv_t;

    logic       CLKA = 1'b0;
    logic       RSTB = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [9:0] addr0 = '0, addr1 = '0;
    logic [3:0] wdata0 = '0, wdata1 = '0;
    logic       clr_start = 1'b0;
    logic       ack0, ack1, rvalid0, rvalid1, clr_busy;
    logic [3:0] rdata0, rdata1;
    logic       ram_en, ram_we, ram_rst;
    logic [9:0] ram_addr;
    logic [3:0] ram_din;
    logic [3:0] ram_dout;

    always #5 CLKA = ~CLKA;

    ramb4_s4_port_arbiter dut (
        .CLKA(CLKA), .RSTB(RSTB),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_rst(ram_rst),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Behavioural RAMB4 port B: write-first, registered output.
    logic [3:0] ram_mem [NW];
    always @(posedge CLKA) begin
        if (ram_en) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_din;
                ram_dout          <= ram_din;
            end else begin
                ram_dout <= ram_mem[ram_addr];
            end
        end
    end

    // Reference model state
    op_t        q0[$];
    op_t        q1[$];
    rv_t        rvq[$];
    int         ack_log[$];
    logic [3:0] ref_mem [NW];
    bit         m_valid, m_busy, m_after_rst;
    int         m_idx, m_last;
    bit         e_en, e_we;
    logic [9:0] e_addr;
    logic [3:0] e_din;

    int         cyc, errors, checks, busy_seen, rel;
    bit         rst_drv, clr_drv;
    int         last_ack_cyc [2];
    logic [3:0] last_rd0, last_rd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic run_cycle();
        bit         ev0, ev1, ea0, ea1;
        logic [3:0] ed0, ed1;
        op_t        op;
        int         g;
        @(negedge CLKA);
        if (m_valid) begin
            ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
            foreach (rvq[i]) begin
                if (rvq[i].due == cyc) begin
                    if (rvq[i].id == 0) begin ev0 = 1'b1; ed0 = rvq[i].data; end
                    else                begin ev1 = 1'b1; ed1 = rvq[i].data; end
                end
            end
            chk("rvalid0", rvalid0, ev0);
            chk("rvalid1", rvalid1, ev1);
            if (ev0) chk("rdata0", rdata0, ed0);
            if (ev1) chk("rdata1", rdata1, ed1);
            if (rvalid0) last_rd0 = rdata0;
            if (rvalid1) last_rd1 = rdata1;
            chk("clr_busy", clr_busy, m_busy);
            chk("ram_en", ram_en, e_en);
            chk("ram_we", ram_we, e_we);
            chk("ram_rst", ram_rst, 1'b0);
            if (e_en) begin
                chk("ram_addr", ram_addr, e_addr);
                chk("ram_din", ram_din, e_din);
            end
            if (m_after_rst) begin
                chk("rst_ram_addr", ram_addr, 10'h000);
                chk("rst_ram_din", ram_din, 4'h0);
            end
            if (clr_busy) busy_seen++;
        end
        while (rvq.size() > 0 && rvq[0].due <= cyc) void'(rvq.pop_front());

        RSTB      = rst_drv;
        clr_start = clr_drv;
        req0 = !rst_drv && (q0.size() > 0);
        if (q0.size() > 0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data; end
        req1 = !rst_drv && (q1.size() > 0);
        if (q1.size() > 0) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data; end
        #1;

        ea0 = 1'b0; ea1 = 1'b0;
        if (!rst_drv && !m_busy && !clr_drv) begin
            if (req0 && !(req1 && m_last == 0)) ea0 = 1'b1;
            else if (req1)                      ea1 = 1'b1;
        end
        if (m_valid) begin
            chk("ack0", ack0, ea0);
            chk("ack1", ack1, ea1);
        end

        m_after_rst = 1'b0;
        if (rst_drv) begin
            m_busy = 1'b1; m_idx = 0; m_last = 1;
            e_en = 1'b0; e_we = 1'b0;
            rvq.delete();
            m_valid = 1'b1;
            m_after_rst = 1'b1;
        end else if (m_busy) begin
            e_en = 1'b1; e_we = 1'b1; e_addr = 10'(m_idx); e_din = CLR_V;
            if (m_idx == NW - 1) begin
                m_busy = 1'b0;
                foreach (ref_mem[i]) ref_mem[i] = CLR_V;
            end
            m_idx++;
        end else if (clr_drv) begin
            m_busy = 1'b1; m_idx = 0;
            e_en = 1'b0; e_we = 1'b0;
        end else if (ea0 || ea1) begin
            g = ea0 ? 0 : 1;
            op = (g == 0) ? q0.pop_front() : q1.pop_front();
            e_en = 1'b1; e_we = op.we; e_addr = op.addr; e_din = op.data;
            if (op.we) ref_mem[op.addr] = op.data;
            else       rvq.push_back(rv_t'{cyc + 2, g, ref_mem[op.addr]});
            m_last = g;
            last_ack_cyc[g] = cyc;
            ack_log.push_back(g);
            $display("txn cyc=%0d req=%0d %s addr=%03h data=%0h", cyc, g,
                     op.we ? "write" : "read ", op.addr,
                     op.we ? op.data : ref_mem[op.addr]);
        end else begin
            e_en = 1'b0; e_we = 1'b0;
        end
        clr_drv = 1'b0;
        cyc++;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + rvq.size()) != 0 && n < limit) begin
            run_cycle();
            n++;
        end
        chk("drain", q0.size() + q1.size() + rvq.size(), 0);
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; busy_seen = 0;
        m_valid = 1'b0; m_busy = 1'b1; m_after_rst = 1'b0; m_idx = 0; m_last = 1;
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0;
        last_rd0 = '0; last_rd1 = '0;
        last_ack_cyc[0] = -1; last_ack_cyc[1] = -1;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        rst_drv = 1'b1; clr_drv = 1'b0;

        // 1: reset release, automatic sweep, req0 held throughout
        repeat (3) run_cycle();
        rst_drv = 1'b0;
        rel = cyc;
        busy_seen = 0;
        q0.push_back(op_t'{1'b0, 10'h02A, 4'h0});
        wait_idle(1200);
        chk("reset_busy_len", busy_seen, 1024);
        chk("first_ack_cycle", last_ack_cyc[0], rel + 1024);
        chk("first_read_clear", last_rd0, CLR_V);

        // 2: write then read through requester 0
        q0.push_back(op_t'{1'b1, 10'h155, 4'hA});
        wait_idle(20);
        q0.push_back(op_t'{1'b0, 10'h155, 4'h0});
        wait_idle(20);
        chk("wr_rd_0x155", last_rd0, 4'hA);

        // 3: contention, after requester 1 was granted last
        for (int i = 0; i < 6; i++)
            q1.push_back(op_t'{1'b1, 10'(10'h010 + i), 4'($urandom)});
        wait_idle(30);
        ack_log.delete();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(op_t'{1'b0, 10'(10'h010 + 2 * i), 4'h0});
            q1.push_back(op_t'{1'b0, 10'(10'h011 + 2 * i), 4'h0});
        end
        wait_idle(30);
        chk("alt_count", ack_log.size(), 6);
        foreach (ack_log[i]) chk("alt_order", ack_log[i], i % 2);

        // 4: clr_start while req1 pending
        q1.push_back(op_t'{1'b0, 10'h155, 4'h0});
        clr_drv = 1'b1;
        busy_seen = 0;
        wait_idle(1200);
        chk("clr_busy_len", busy_seen, 1024);
        chk("clr_read_0x155", last_rd1, CLR_V);
        for (int i = 0; i < 4; i++)
            q0.push_back(op_t'{1'b0, 10'(10'h010 + i), 4'h0});
        wait_idle(30);

        // 5: in-flight read dropped by reset, then reset mid-sweep at cnt=500
        q0.push_back(op_t'{1'b0, 10'h155, 4'h0});
        for (int n = 0; n < 10 && q0.size() > 0; n++) run_cycle();
        rst_drv = 1'b1;
        run_cycle();
        rst_drv = 1'b0;
        for (int n = 0; n < 1200 && m_idx != 500; n++) run_cycle();
        chk("sweep_reached_500", m_idx, 500);
        rst_drv = 1'b1;
        run_cycle();
        rst_drv = 1'b0;
        busy_seen = 0;
        for (int n = 0; n < 1200 && m_busy; n++) run_cycle();
        run_cycle();
        chk("restart_busy_len", busy_seen, 1024);

        // 6: back-to-back write by 0 then read by 1
        q0.push_back(op_t'{1'b1, 10'h3FF, 4'h5});
        run_cycle();
        q1.push_back(op_t'{1'b0, 10'h3FF, 4'h0});
        run_cycle();
        wait_idle(20);
        chk("b2b_rdata1", last_rd1, 4'h5);
        chk("b2b_gap", last_ack_cyc[1] - last_ack_cyc[0], 1);

        // 7: randomized mixed traffic on a small address window
        for (int n = 0; n < 300; n++) begin
            if (q0.size() == 0 && $urandom_range(1, 0) == 1)
                q0.push_back(op_t'{1'($urandom), 10'($urandom_range(1023, 1008)), 4'($urandom)});
            if (q1.size() == 0 && $urandom_range(1, 0) == 1)
                q1.push_back(op_t'{1'($urandom), 10'($urandom_range(1023, 1008)), 4'($urandom)});
            run_cycle();
        end
        wait_idle(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
